// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types for the EX/MEM pipeline stage and its skid buffer.
// Holds the default-width payload layout, its width, and the buffer occupancy states.
package ex_mem_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned RADDR_W_DEF = 5;

    // Field order matters: ex_mem_stage packs its local payload in the same order.
    typedef struct packed {
        logic                   reg_write;
        logic                   mem_to_reg;
        logic                   mem_read;
        logic                   mem_write;
        logic                   branch;
        logic                   zero;
        logic [XLEN_DEF-1:0]    alu_result;
        logic [XLEN_DEF-1:0]    store_data;
        logic [XLEN_DEF-1:0]    branch_sum;
        logic [RADDR_W_DEF-1:0] rd;
    } ex_mem_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(ex_mem_payload_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry skid buffer with synchronous flush.
// in_ready depends only on registered occupancy and reset, never on out_ready.
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int unsigned      W         = 8,
    parameter logic [W-1:0]     RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    state_t       state;
    logic [W-1:0] head_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         pop;

    // Handshake qualifiers derived from occupancy.
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = reset & (state != TWO);
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = head_q;
    end

    // Occupancy and storage update; flush wins over accept and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            head_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= TWO;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready handshake and flush.
// Optional macro EX_MEM_FWD_EN adds fwd_we/fwd_rd/fwd_data taken from the head entry.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     RADDR_W  = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_reg_write,
    input  logic               in_mem_to_reg,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_branch,
    input  logic               in_zero,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_store_data,
    input  logic [XLEN-1:0]    in_branch_sum,
    input  logic [RADDR_W-1:0] in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_reg_write,
    output logic               out_mem_to_reg,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_branch,
    output logic               out_zero,
    output logic [XLEN-1:0]    out_alu_result,
    output logic [XLEN-1:0]    out_store_data,
    output logic [XLEN-1:0]    out_branch_sum,
    output logic [RADDR_W-1:0] out_rd
`ifdef EX_MEM_FWD_EN
    ,
    output logic               fwd_we,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data
`endif
);

    // Same layout as ex_mem_payload_t, but sized by this instance's parameters.
    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               zero;
        logic [XLEN-1:0]    alu_result;
        logic [XLEN-1:0]    store_data;
        logic [XLEN-1:0]    branch_sum;
        logic [RADDR_W-1:0] rd;
    } payload_t;

    localparam int unsigned PW = $bits(payload_t);
    localparam payload_t RST_PAYLOAD = '{
        reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        branch: 1'b0, zero: 1'b0, alu_result: '0, store_data: '0,
        branch_sum: RESET_PC, rd: '0
    };

    payload_t in_p;
    payload_t head_p;

    // Pack the EX-side fields into one payload word.
    always_comb begin
        in_p            = RST_PAYLOAD;
        in_p.reg_write  = in_reg_write;
        in_p.mem_to_reg = in_mem_to_reg;
        in_p.mem_read   = in_mem_read;
        in_p.mem_write  = in_mem_write;
        in_p.branch     = in_branch;
        in_p.zero       = in_zero;
        in_p.alu_result = in_alu_result;
        in_p.store_data = in_store_data;
        in_p.branch_sum = in_branch_sum;
        in_p.rd         = in_rd;
    end

    pipe_skid_buf #(
        .W         (PW),
        .RESET_VAL (RST_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_p)
    );

    // Unpack the head entry; side-effecting controls are squashed on bubbles.
    always_comb begin
        out_reg_write  = out_valid & head_p.reg_write;
        out_mem_read   = out_valid & head_p.mem_read;
        out_mem_write  = out_valid & head_p.mem_write;
        out_branch     = out_valid & head_p.branch;
        out_mem_to_reg = head_p.mem_to_reg;
        out_zero       = head_p.zero;
        out_alu_result = head_p.alu_result;
        out_store_data = head_p.store_data;
        out_branch_sum = head_p.branch_sum;
        out_rd         = head_p.rd;
    end

`ifdef EX_MEM_FWD_EN
    // Forwarding source for EX; writes to x0 are never forwarded.
    always_comb begin
        fwd_we   = out_valid & head_p.reg_write & (head_p.rd != '0);
        fwd_rd   = head_p.rd;
        fwd_data = head_p.alu_result;
    end
`endif

endmodule
